// File: rtl/diagv2_test_seq.sv
// Diagnostic test sequencer: loads, resets, runs and scores each test program on a core.
// Optional RUN watchdog is enabled by defining DIAGV2_SEQ_TIMEOUT_EN.
module diagv2_test_seq #(
   parameter int TESTS          = 50,
   parameter int RESET_CYCLES   = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ecall,
   input  logic [63:0] syscall_num,
   input  logic [63:0] syscall_arg,
   input  logic        load_ack,
   output logic        load_req,
   output logic [6:0]  load_idx,
   output logic        core_reset,
   output logic        core_halt,
   output logic        bad_ecall,
   output logic [6:0]  pass_cnt,
   output logic [6:0]  fail_cnt,
   output logic        done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RST  = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_EVAL = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [63:0] EXIT_NUM = 64'd93;
   localparam logic [6:0]  LAST_IDX = 7'(TESTS - 1);
   localparam logic [3:0]  RST_LAST = 4'(RESET_CYCLES - 1);

   logic [2:0] state_q, state_d;
   logic [3:0] rst_cnt_q, rst_cnt_d;
   logic [6:0] load_idx_q, load_idx_d;
   logic [6:0] pass_cnt_q, pass_cnt_d;
   logic [6:0] fail_cnt_q, fail_cnt_d;
   logic       load_req_q, load_req_d;
   logic       core_reset_q, core_reset_d;
   logic       core_halt_q, core_halt_d;
   logic       bad_ecall_q, bad_ecall_d;
   logic       done_q, done_d;
   logic       timeout;

`ifdef DIAGV2_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;
`endif

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      load_idx_d  = load_idx_q;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      bad_ecall_d = 1'b0;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
      wd_d        = wd_q;
      timeout     = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
      timeout     = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_LOAD;
               load_idx_d = 7'd0;
               pass_cnt_d = 7'd0;
               fail_cnt_d = 7'd0;
            end
         end
         S_LOAD: begin
            if (load_ack) begin
               state_d   = S_RST;
               rst_cnt_d = 4'd0;
            end
         end
         S_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = S_RUN;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
               wd_d    = '0;
`endif
            end else begin
               rst_cnt_d = rst_cnt_q + 4'd1;
            end
         end
         S_RUN: begin
            // The syscall registers are consumed at the ecall edge itself; an ecall wins over a timeout.
            if (ecall) begin
               state_d = S_EVAL;
               if (syscall_num == EXIT_NUM) begin
                  if (syscall_arg == 64'd0) pass_cnt_d = pass_cnt_q + 7'd1;
                  else                      fail_cnt_d = fail_cnt_q + 7'd1;
               end else begin
                  fail_cnt_d  = fail_cnt_q + 7'd1;
                  bad_ecall_d = 1'b1;
               end
            end else if (timeout) begin
               state_d    = S_EVAL;
               fail_cnt_d = fail_cnt_q + 7'd1;
            end else begin
`ifdef DIAGV2_SEQ_TIMEOUT_EN
               wd_d = wd_q + 1'b1;
`endif
            end
         end
         S_EVAL: begin
            if (load_idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               state_d    = S_LOAD;
               load_idx_d = load_idx_q + 7'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with the state they describe.
      load_req_d   = (state_d == S_LOAD);
      core_reset_d = !((state_d == S_RUN) || (state_d == S_EVAL));
      core_halt_d  = !((state_d == S_RST) || (state_d == S_RUN));
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rst_cnt_q    <= 4'd0;
         load_idx_q   <= 7'd0;
         pass_cnt_q   <= 7'd0;
         fail_cnt_q   <= 7'd0;
         load_req_q   <= 1'b0;
         core_reset_q <= 1'b1;
         core_halt_q  <= 1'b1;
         bad_ecall_q  <= 1'b0;
         done_q       <= 1'b0;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
         wd_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         load_idx_q   <= load_idx_d;
         pass_cnt_q   <= pass_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         load_req_q   <= load_req_d;
         core_reset_q <= core_reset_d;
         core_halt_q  <= core_halt_d;
         bad_ecall_q  <= bad_ecall_d;
         done_q       <= done_d;
`ifdef DIAGV2_SEQ_TIMEOUT_EN
         wd_q         <= wd_d;
`endif
      end
   end

   assign load_req   = load_req_q;
   assign load_idx   = load_idx_q;
   assign core_reset = core_reset_q;
   assign core_halt  = core_halt_q;
   assign bad_ecall  = bad_ecall_q;
   assign pass_cnt   = pass_cnt_q;
   assign fail_cnt   = fail_cnt_q;
   assign done       = done_q;

endmodule

// File: tb/tb_diagv2_test_seq.sv
// Randomized bench for diagv2_test_seq: per-test protocol checks against pass/fail tallies.
// Watchdog scenarios are exercised when DIAGV2_SEQ_TIMEOUT_EN is defined.
module tb_diagv2_test_seq;

   localparam int TESTS          = 5;
   localparam int RESET_CYCLES   = 4;
   localparam int TIMEOUT_CYCLES = 20;

   logic        clk = 1'b0;
   logic        reset, start, ecall, load_ack;
   logic [63:0] syscall_num, syscall_arg;
   logic        load_req, core_reset, core_halt, bad_ecall, done;
   logic [6:0]  load_idx, pass_cnt, fail_cnt;

   int errors = 0;
   int checks = 0;
   int exp_pass, exp_fail;

   diagv2_test_seq #(
      .TESTS(TESTS), .RESET_CYCLES(RESET_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .ecall(ecall),
      .syscall_num(syscall_num), .syscall_arg(syscall_arg), .load_ack(load_ack),
      .load_req(load_req), .load_idx(load_idx), .core_reset(core_reset),
      .core_halt(core_halt), .bad_ecall(bad_ecall), .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rv_core_reset", core_reset, 1);
      chk("rv_core_halt", core_halt, 1);
      chk("rv_load_req", load_req, 0);
      chk("rv_load_idx", load_idx, 0);
      chk("rv_pass", pass_cnt, 0);
      chk("rv_fail", fail_cnt, 0);
      chk("rv_bad", bad_ecall, 0);
      chk("rv_done", done, 0);
   endtask

   task automatic start_run();
      start = 1; tick(); start = 0;
      exp_pass = 0;
      exp_fail = 0;
      chk("st_pass", pass_cnt, 0);
      chk("st_fail", fail_cnt, 0);
      chk("st_done", done, 0);
   endtask

   // LOAD handshake with random ack delay, then the RST window (stray ecalls must be ignored)
   task automatic do_load(input int idx);
      int nw;
      chk("ld_req", load_req, 1);
      chk("ld_idx", load_idx, idx);
      chk("ld_creset", core_reset, 1);
      chk("ld_halt", core_halt, 1);
      chk("ld_done", done, 0);
      nw = $urandom_range(0, 3);
      for (int i = 0; i < nw; i++) begin
         start = 1; tick(); start = 0;
         chk("ld_hold", load_req, 1);
      end
      load_ack = 1; tick(); load_ack = 0;
      for (int i = 0; i < RESET_CYCLES; i++) begin
         chk("rst_creset", core_reset, 1);
         chk("rst_halt", core_halt, 0);
         chk("rst_lreq", load_req, 0);
         ecall = 1; syscall_num = 64'd64; tick(); ecall = 0;
      end
      chk("run_creset", core_reset, 0);
      chk("run_halt", core_halt, 0);
   endtask

   // mode 0: ecall after short random wait; 1: watchdog expiry; 2: ecall on last watchdog cycle; 3: long wait then ecall
   task automatic do_test(input int idx, input int mode, input logic [63:0] num, input logic [63:0] arg);
      int  nw;
      logic exp_bad;
      do_load(idx);
      case (mode)
         1: nw = TIMEOUT_CYCLES;
         2: nw = TIMEOUT_CYCLES - 1;
         3: nw = 30;
         default: nw = $urandom_range(0, 5);
      endcase
      for (int i = 0; i < nw; i++) begin
         chk("run_halt_w", core_halt, 0);
         start = ($urandom_range(0, 1) == 1);
         load_ack = ($urandom_range(0, 1) == 1);
         tick();
         start = 0; load_ack = 0;
      end
      if (mode != 1) begin
         ecall = 1; syscall_num = num; syscall_arg = arg;
         tick();
         ecall = 0; syscall_num = {$urandom, $urandom}; syscall_arg = {$urandom, $urandom};
      end
      exp_bad = 1'b0;
      if (mode == 1) exp_fail++;
      else if (num == 64'd93) begin
         if (arg == 64'd0) exp_pass++;
         else exp_fail++;
      end else begin
         exp_fail++;
         exp_bad = 1'b1;
      end
      chk("ev_halt", core_halt, 1);
      chk("ev_bad", bad_ecall, exp_bad);
      chk("ev_pass", pass_cnt, exp_pass);
      chk("ev_fail", fail_cnt, exp_fail);
      chk("ev_sum", 64'(pass_cnt) + 64'(fail_cnt), idx + 1);
      tick();
      chk("post_bad", bad_ecall, 0);
      if (idx == TESTS - 1) begin
         chk("dn_done", done, 1);
         chk("dn_idx", load_idx, TESTS - 1);
         chk("dn_halt", core_halt, 1);
         chk("dn_creset", core_reset, 1);
      end else begin
         chk("nx_done", done, 0);
      end
   endtask

   task automatic random_test(input int idx, input int sel);
      logic [63:0] num, arg;
      case (sel)
         0: begin num = 64'd93; arg = 64'd0; end
         1: begin num = 64'd93; arg = {$urandom, $urandom} | 64'd1; end
         2: begin num = 64'd64; arg = {$urandom, $urandom}; end
         default: begin num = {32'd0, $urandom}; arg = 64'(1 - $urandom_range(0, 1)); end
      endcase
      do_test(idx, 0, num, arg);
   endtask

   initial begin
      reset = 1; start = 1; ecall = 0; load_ack = 0;
      syscall_num = 0; syscall_arg = 0;
      tick(); tick(); tick();
      chk_reset_vals();
      reset = 0; start = 0;
      tick();
      chk("idle_lreq", load_req, 0);
      chk("idle_halt", core_halt, 1);

      // run 1: directed pass / nonzero exit / bad syscall, then random outcomes
      start_run();
      for (int t = 0; t < TESTS; t++)
         random_test(t, (t < 3) ? t : $urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
         load_ack = 1; tick(); load_ack = 0;
         chk("dn_hold", done, 1);
         chk("dn_lreq", load_req, 0);
      end

      // run 2 from DONE; reset mid-RUN of test 1 after an ignored start pulse
      start_run();
      random_test(0, $urandom_range(0, 3));
      do_load(1);
      start = 1; tick(); start = 0;
      chk("run_start_ign", core_halt, 0);
      chk("run_start_lreq", load_req, 0);
      chk("run_idx1", load_idx, 1);
      reset = 1; start = 1; tick();
      chk_reset_vals();
      reset = 0; start = 0; tick();
      chk("rst_start_ign", load_req, 0);
      chk("rst_idle_halt", core_halt, 1);

      // run 3: watchdog behaviour (or its absence)
      start_run();
`ifdef DIAGV2_SEQ_TIMEOUT_EN
      do_test(0, 1, 64'd0, 64'd0);
      do_test(1, 2, 64'd93, 64'd0);
`else
      do_test(0, 3, 64'd93, 64'd0);
      do_test(1, 3, 64'd93, 64'd7);
`endif
      for (int t = 2; t < TESTS; t++)
         random_test(t, $urandom_range(0, 3));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/diagv2_test_seq.md
DIAGV2_TEST_SEQ -- requirements
Module: diagv2_test_seq

Interface
REQ-001 SHALL have parameter TESTS, default 50, number of test programs per run (legal 1..127).
REQ-002 SHALL have parameter RESET_CYCLES, default 4, core reset pulse length in cycles (legal 1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, RUN watchdog limit (used only with DIAGV2_SEQ_TIMEOUT_EN).
REQ-004 SHALL have ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run.
- ecall  in  1  core is executing ECALL.
- syscall_num  in  64  core register a7/x17.
- syscall_arg  in  64  core register a0/x10.
- load_ack  in  1  external loader has filled imem/dmem for load_idx.
- load_req  out  1  request loader to fill memories.
- load_idx  out  7  index of the current test.
- core_reset  out  1  core reset.
- core_halt  out  1  core stall/clock-enable inhibit.
- bad_ecall  out  1  one-cycle pulse; unsupported syscall.
- pass_cnt  out  7  tests exited with status 0.
- fail_cnt  out  7  tests failed.
- done  out  1  run complete.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, RST, RUN, EVAL, DONE; all outputs registered.
REQ-006 IDLE: core_reset=1, core_halt=1; start=1 -> LOAD next cycle, load_idx:=0, pass_cnt:=0, fail_cnt:=0, done:=0.
REQ-007 LOAD: load_req=1, core_reset=1, core_halt=1; load_req held until load_ack sampled high; then -> RST, load_req=0 from the next cycle.
REQ-008 load_ack outside LOAD SHALL be ignored.
REQ-009 RST: core_reset=1, core_halt=0 for exactly RESET_CYCLES cycles, then -> RUN.
REQ-010 RUN: core_reset=0, core_halt=0; ecall sampled high -> EVAL, capturing syscall_num and syscall_arg in the same edge.
REQ-011 EVAL (exactly one cycle): core_halt=1; the captured num==93 and arg==0 -> pass_cnt+1; num==93 and arg!=0 -> fail_cnt+1; num!=93 -> fail_cnt+1 and bad_ecall=1 for that cycle.
REQ-012 EVAL exit: load_idx==TESTS-1 -> DONE; otherwise load_idx+1 and -> LOAD.
REQ-013 DONE: done=1, core_halt=1, core_reset=1; start=1 -> same action as REQ-006.
REQ-014 start SHALL be ignored in LOAD, RST, RUN and EVAL.
REQ-015 pass_cnt+fail_cnt SHALL equal load_idx+1 after each EVAL; the counters never wrap for legal TESTS.
REQ-016 Latency: ecall in RUN -> core_halt=1 on the next cycle; last EVAL -> done=1 on the next cycle.

Reset
REQ-017 reset=1 at a clock edge SHALL force IDLE, core_reset=1, core_halt=1, load_req=0, load_idx=0, pass_cnt=0, fail_cnt=0, bad_ecall=0, done=0, and the watchdog counter to 0, from any state including mid-LOAD and mid-RUN.
REQ-018 While reset=1, start SHALL be ignored.

Configuration
REQ-019 Macro DIAGV2_SEQ_TIMEOUT_EN defined: a watchdog counts RUN cycles (cleared on RUN entry); reaching TIMEOUT_CYCLES without ecall -> EVAL scored as fail (no bad_ecall).
REQ-020 Simultaneous ecall and timeout SHALL score per REQ-011, using ecall.
REQ-021 Macro undefined: no watchdog logic; RUN lasts until ecall indefinitely.

Verification
REQ-022 TESTS=3; start; ack each load after 2 cycles; ecall with num=93, arg=0 each test -> pass_cnt=3, fail_cnt=0, done=1, load_idx=2.
REQ-023 TESTS=2; test0 exits num=93, arg=5; test1 exits num=93, arg=0 -> pass_cnt=1, fail_cnt=1.
REQ-024 ecall with num=64 -> bad_ecall high exactly one cycle, fail_cnt+1, sequencer advances to LOAD.
REQ-025 RESET_CYCLES=4 -> core_reset high exactly 4 cycles in RST after the load_ack edge; core_halt=0 throughout those cycles; ecall during RST ignored.
REQ-026 reset asserted in RUN with load_idx=1 -> next cycle IDLE, all outputs at REQ-017 values; start pulse in RUN has no effect.
REQ-027 DIAGV2_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, no ecall -> EVAL after 20 RUN cycles, fail_cnt+1; same ecall and timeout cycle with num=93, arg=0 -> pass_cnt+1.
